mch_wfm_capture: RTL and testbench

MCH_WFM_CAPTURE -- requirements
Module: mch_wfm_capture

---
 rtl/wfc_pkg.sv | 23 ++
 rtl/wfc_delay_line.sv | 33 +++
 rtl/mch_wfm_capture.sv | 188 ++++++++++++++++++
 tb/tb_mch_wfm_capture.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wfc_pkg.sv
// Shared types and width helpers for the multi-channel waveform capture block.
//   wfc_state_e  : capture controller states
//   diff_width() : width of the signed sample-minus-baseline difference
//   cnt_width()  : width of the record sample down-counter
package wfc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_HOLDOFF = 2'd3
   } wfc_state_e;

   function automatic int diff_width(input int dw);
      return dw + 1;
   endfunction

   // Holds PRE+POST-1 as the down-counter load value.
   function automatic int cnt_width(input int pre, input int post);
      return (pre + post > 1) ? $clog2(pre + post) : 1;
   endfunction

endpackage

// File: rtl/wfc_delay_line.sv
// Fixed-length sample delay built as a circular buffer.
// Ports:
//   clk_adc  in   ADC sample clock
//   RESET    in   async active-low reset (pointer only; RAM is not cleared)
//   din      in   DW-bit sample written every cycle
//   dout     out  sample written DEPTH cycles earlier (registered read)
module wfc_delay_line #(
   parameter int DW    = 14,
   parameter int DEPTH = 80
) (
   input  logic          clk_adc,
   input  logic          RESET,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] ptr;

   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) ptr <= '0;
      else        ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   end

   // Read-before-write on the same slot: the old contents are exactly DEPTH writes old.
   always_ff @(posedge clk_adc) begin
      mem[ptr] <= din;
      dout     <= mem[ptr];
   end

endmodule

// File: rtl/mch_wfm_capture.sv
// Multi-channel triggered waveform capture.
// Records PRE samples before and POST samples from the trigger onward on all
// channels, triggered by an external pulse or a per-channel threshold crossing.
// Ports:
//   clk_adc, RESET         clock, async active-low reset
//   adc_data, baseline     packed NCH x DW samples / baselines
//   ext_trig               async external trigger (synchronised here)
//   arm, trig_mask         trigger enable level / per-channel internal enable
//   wr_full                downstream full; drops the current sample
//   out_data/valid/first/last  record stream
//   trig_src, busy, overflow, evt_cnt  status
//   ts_out                 48-bit trigger timestamp, only with WFC_TIMESTAMP_EN
// Optional feature macro: WFC_TIMESTAMP_EN
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | not accepting triggers (disarmed or delay line not filled)
// ST_ARMED   | waiting for an external or channel trigger
// ST_CAPTURE | streaming PRE+POST delayed samples
// ST_HOLDOFF | dead time after a record before re-arming
module mch_wfm_capture
   import wfc_pkg::*;
#(
   parameter int NCH     = 2,
   parameter int DW      = 14,
   parameter int PRE     = 80,
   parameter int POST    = 176,
   parameter int THRES   = 80,
   parameter int HOLDOFF = 16
) (
   input  logic              clk_adc,
   input  logic              RESET,
   input  logic [NCH*DW-1:0] adc_data,
   input  logic [NCH*DW-1:0] baseline,
   input  logic              ext_trig,
   input  logic              arm,
   input  logic [NCH-1:0]    trig_mask,
   input  logic              wr_full,
   output logic [NCH*DW-1:0] out_data,
   output logic              out_valid,
   output logic              out_first,
   output logic              out_last,
   output logic [NCH:0]      trig_src,
   output logic              busy,
   output logic              overflow,
   output logic [15:0]       evt_cnt
`ifdef WFC_TIMESTAMP_EN
   ,
   output logic [47:0]       ts_out
`endif
);

   localparam int SW = diff_width(DW);
   localparam int CW = cnt_width(PRE, POST);
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam int FW = $clog2(PRE + 1);
   localparam logic signed [SW-1:0] THR_S   = SW'(THRES);
   localparam logic [CW-1:0]        CAP_LD  = CW'(PRE + POST - 1);

   logic [NCH*DW-1:0] adc_q;
   logic [NCH*DW-1:0] dly;
   logic [NCH-1:0]    ch_hit_d;
   logic [NCH-1:0]    ch_hit;
   logic              sync1, sync2, sync3;
   logic              ext_hit;
   logic              any_hit;
   logic [FW-1:0]     fill_cnt;
   logic              fill_done;
   wfc_state_e        state, nxt;
   logic              accept;
   logic [CW-1:0]     cap_cnt;
   logic [HW-1:0]     hold_cnt;
   logic              in_cap;

   // The adc_q and out_data stages line the delayed stream up with the
   // two-cycle trigger path (hit register + FSM transition), so the first
   // record sample is exactly PRE samples before the trigger sample.
   always_ff @(posedge clk_adc) begin
      adc_q    <= adc_data;
      out_data <= dly;
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      logic signed [SW-1:0] diff;
      assign diff = $signed({1'b0, adc_data[g*DW +: DW]}) - $signed({1'b0, baseline[g*DW +: DW]});
      assign ch_hit_d[g] = trig_mask[g] & (diff > THR_S);

      wfc_delay_line #(.DW(DW), .DEPTH(PRE)) u_dly (
         .clk_adc (clk_adc),
         .RESET   (RESET),
         .din     (adc_q[g*DW +: DW]),
         .dout    (dly[g*DW +: DW])
      );
   end

   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         ch_hit <= '0;
      end else begin
         sync1  <= ext_trig;
         sync2  <= sync1;
         sync3  <= sync2;
         ch_hit <= ch_hit_d;
      end
   end

   assign ext_hit = sync2 & ~sync3;
   assign any_hit = ext_hit | (|ch_hit);

   // Fill down-counter: zero once PRE samples have entered the delay line.
   assign fill_done = (fill_cnt == '0);

   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET)         fill_cnt <= FW'(PRE);
      else if (!fill_done) fill_cnt <= fill_cnt - 1'b1;
   end

   always_comb begin
      nxt    = state;
      accept = 1'b0;
      case (state)
         ST_IDLE:    if (arm && fill_done) nxt = ST_ARMED;
         ST_ARMED: begin
            if (!arm) nxt = ST_IDLE;
            else if (any_hit) begin
               nxt    = ST_CAPTURE;
               accept = 1'b1;
            end
         end
         ST_CAPTURE: if (cap_cnt == '0) nxt = ST_HOLDOFF;
         ST_HOLDOFF: if (hold_cnt == '0) nxt = arm ? ST_ARMED : ST_IDLE;
         default:    nxt = ST_IDLE;
      endcase
   end

   assign in_cap = (state == ST_CAPTURE);
   assign busy   = (state == ST_CAPTURE) || (state == ST_HOLDOFF);

   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) begin
         state     <= ST_IDLE;
         cap_cnt   <= '0;
         hold_cnt  <= '0;
         trig_src  <= '0;
         evt_cnt   <= '0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         state <= nxt;
         if (accept) begin
            cap_cnt  <= CAP_LD;
            trig_src <= {ext_hit, ch_hit};
            evt_cnt  <= evt_cnt + 16'd1;
         end else if (in_cap && cap_cnt != '0) begin
            cap_cnt <= cap_cnt - 1'b1;
         end

         if (in_cap && cap_cnt == '0)                    hold_cnt <= HW'(HOLDOFF - 1);
         else if (state == ST_HOLDOFF && hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;

         // Position flags follow the sample counter even when the sample is dropped.
         out_valid <= in_cap & ~wr_full;
         out_first <= in_cap && (cap_cnt == CAP_LD);
         out_last  <= in_cap && (cap_cnt == '0);
         overflow  <= overflow | (in_cap & wr_full);
      end
   end

`ifdef WFC_TIMESTAMP_EN
   logic [47:0] ts_cnt;

   always_ff @(posedge clk_adc or negedge RESET) begin
      if (!RESET) begin
         ts_cnt <= '0;
         ts_out <= '0;
      end else begin
         ts_cnt <= ts_cnt + 48'd1;
         if (accept) ts_out <= ts_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_mch_wfm_capture.sv
// Self-checking bench for mch_wfm_capture (default parameters).
// Honors WFC_TIMESTAMP_EN when the design is built with it.
module tb_mch_wfm_capture;

   localparam int NCH = 2, DW = 14, PRE = 80, POST = 176, THRES = 80, HOLDOFF = 16;
   localparam int REC  = PRE + POST;
   localparam int MAXC = 16384;

   logic              clk_adc;
   logic              RESET;
   logic [NCH*DW-1:0] adc_data;
   logic [NCH*DW-1:0] baseline;
   logic              ext_trig;
   logic              arm;
   logic [NCH-1:0]    trig_mask;
   logic              wr_full;
   logic [NCH*DW-1:0] out_data;
   logic              out_valid, out_first, out_last;
   logic [NCH:0]      trig_src;
   logic              busy, overflow;
   logic [15:0]       evt_cnt;
`ifdef WFC_TIMESTAMP_EN
   logic [47:0]       ts_out;
`endif

   mch_wfm_capture #(
      .NCH(NCH), .DW(DW), .PRE(PRE), .POST(POST), .THRES(THRES), .HOLDOFF(HOLDOFF)
   ) dut (
      .clk_adc   (clk_adc),
      .RESET     (RESET),
      .adc_data  (adc_data),
      .baseline  (baseline),
      .ext_trig  (ext_trig),
      .arm       (arm),
      .trig_mask (trig_mask),
      .wr_full   (wr_full),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_first (out_first),
      .out_last  (out_last),
      .trig_src  (trig_src),
      .busy      (busy),
      .overflow  (overflow),
      .evt_cnt   (evt_cnt)
`ifdef WFC_TIMESTAMP_EN
      ,
      .ts_out    (ts_out)
`endif
   );

   initial clk_adc = 1'b0;
   always #5 clk_adc = ~clk_adc;

   // Input history per clock edge and a transaction-level view of records.
   logic [NCH*DW-1:0] samp   [MAXC];
   logic              wf_h   [MAXC];
   logic              ext_h  [MAXC];
   logic [NCH-1:0]    mask_h [MAXC];
   logic              arm_h  [MAXC];
   logic              rst_h  [MAXC];

   int          m;
   int          rst_edge;
   int          rec_t;
   bit          rec_on;
   logic [NCH:0] exp_src;
   int          exp_evt;
   bit          exp_ovf;
   longint      exp_ts;

   int          n_valid, n_first, n_last, flag_err, data_err, ts_err;
   logic [NCH*DW-1:0] first_data;

   int          ramp;
   int          ch1_force;
   int          compared, mismatched;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // Trigger sources visible in the DUT right after edge k.
   function automatic logic [NCH:0] hits_at(input int k);
      logic [NCH:0] h;
      int d;
      h = '0;
      if (k < 3) return h;
      if (rst_h[k] || rst_h[k-1] || rst_h[k-2]) return h;
      h[NCH] = ext_h[k-1] & ~ext_h[k-2];
      for (int c = 0; c < NCH; c++) begin
         d = int'(samp[k][c*DW +: DW]) - int'(baseline[c*DW +: DW]);
         h[c] = mask_h[k][c] && (d > THRES);
      end
      return h;
   endfunction

   task automatic drive_next();
      logic [DW-1:0] c0, c1;
      c0 = DW'(ramp);
      ramp++;
      if (ch1_force >= 0) c1 = DW'(ch1_force);
      else                c1 = DW'(1000 + $urandom_range(0, 60));
      adc_data = {c1, c0};
   endtask

   task automatic clear_stats();
      n_valid = 0; n_first = 0; n_last = 0; flag_err = 0; data_err = 0; ts_err = 0;
      first_data = '0;
   endtask

   task automatic tick();
      logic [NCH:0] h;
      bit in_rec, e_valid, e_first, e_last, e_busy;
      int idx;
      @(posedge clk_adc);
      m++;
      samp[m]   = adc_data;
      wf_h[m]   = wr_full;
      ext_h[m]  = ext_trig;
      mask_h[m] = trig_mask;
      arm_h[m]  = arm;
      rst_h[m]  = ~RESET;
      if (!RESET) begin
         rst_edge = m;
         rec_on   = 0;
         exp_evt  = 0;
         exp_src  = '0;
         exp_ovf  = 0;
      end else begin
         // A hit is taken one edge after it is seen, if armed: delay line filled
         // and the previous record plus its holdoff has fully elapsed.
         h = hits_at(m - 1);
         if (h != '0 && arm_h[m] && (m - 1 - rst_edge) >= PRE + 1 &&
             (!rec_on || (m - 1) >= rec_t + REC + HOLDOFF + 1)) begin
            rec_t   = m - 1;
            rec_on  = 1;
            exp_src = h;
            exp_evt = (exp_evt + 1) % 65536;
            exp_ts  = longint'(m - 1 - rst_edge);
         end
      end
      @(negedge clk_adc);
      if (RESET) begin
         in_rec  = rec_on && m >= rec_t + 2 && m <= rec_t + REC + 1;
         idx     = m - rec_t - 2;
         e_valid = in_rec && !wf_h[m];
         e_first = in_rec && idx == 0;
         e_last  = in_rec && idx == REC - 1;
         e_busy  = rec_on && m >= rec_t + 1 && m <= rec_t + REC + HOLDOFF;
         if (in_rec && wf_h[m]) exp_ovf = 1;
         if (out_valid !== e_valid || out_first !== e_first ||
             out_last !== e_last || busy !== e_busy) flag_err++;
         if (m - rst_edge > PRE + 4 && out_data !== samp[m - 2 - PRE]) data_err++;
`ifdef WFC_TIMESTAMP_EN
         if (in_rec && ts_out !== 48'(exp_ts)) ts_err++;
`endif
         if (out_valid) n_valid++;
         if (out_first) n_first++;
         if (out_last)  n_last++;
         if (out_first && out_valid) first_data = out_data;
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         drive_next();
      end
   endtask

   task automatic pulse();
      ext_trig = 1'b1;
      step(3);
      ext_trig = 1'b0;
   endtask

   task automatic chk_record(input string tag, input int nv);
      chk({tag, "_flags"}, 64'(flag_err), 64'd0);
      chk({tag, "_data"},  64'(data_err), 64'd0);
      chk({tag, "_nvalid"}, 64'(n_valid), 64'(nv));
      chk({tag, "_evt"},   64'(evt_cnt), 64'(exp_evt));
      chk({tag, "_src"},   64'(trig_src), 64'(exp_src));
      chk({tag, "_ovf"},   64'(overflow), 64'(exp_ovf));
`ifdef WFC_TIMESTAMP_EN
      chk({tag, "_ts"},    64'(ts_err), 64'd0);
`endif
   endtask

   initial begin
      int guard;
      compared = 0; mismatched = 0;
      m = 0; rst_edge = 0; rec_t = 0; rec_on = 0;
      exp_src = '0; exp_evt = 0; exp_ovf = 0; exp_ts = 0;
      ramp = 0; ch1_force = -1;
      clear_stats();
      RESET = 1'b0; arm = 1'b1; ext_trig = 1'b0; wr_full = 1'b0; trig_mask = '0;
      baseline = {14'd1000, 14'd1000};
      drive_next();

      // Reset state
      step(4);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_first", 64'(out_first), 64'd0);
      chk("rst_last",  64'(out_last),  64'd0);
      chk("rst_busy",  64'(busy),      64'd0);
      chk("rst_ovf",   64'(overflow),  64'd0);
      chk("rst_evt",   64'(evt_cnt),   64'd0);
      chk("rst_src",   64'(trig_src),  64'd0);
      RESET = 1'b1;

      // External trigger on a ramp
      step(150 + $urandom_range(0, 30));
      clear_stats();
      pulse();
      step(REC + HOLDOFF + 20);
      chk_record("ext", 256);
      chk("ext_src_const", 64'(trig_src), 64'h4);
      chk("ext_evt_const", 64'(evt_cnt), 64'd1);
      chk("ext_nfirst", 64'(n_first), 64'd1);
      chk("ext_nlast",  64'(n_last),  64'd1);
      chk("ext_first_sample", 64'(first_data), 64'(samp[rec_t - PRE]));

      // Internal trigger just above threshold on channel 1
      trig_mask = 2'b10;
      step(5 + $urandom_range(0, 10));
      clear_stats();
      ch1_force = 1081; drive_next();
      step(1);
      ch1_force = -1;
      step(REC + HOLDOFF + 20);
      chk_record("int1081", 256);
      chk("int1081_src_const", 64'(trig_src), 64'h2);
      chk("int1081_evt_const", 64'(evt_cnt), 64'd2);

      // Exactly at threshold: no trigger
      clear_stats();
      ch1_force = 1080; drive_next();
      step(1);
      ch1_force = -1;
      step(40);
      chk("int1080_evt", 64'(evt_cnt), 64'd2);
      chk("int1080_nvalid", 64'(n_valid), 64'd0);
      trig_mask = 2'b00;
      step(5);

      // Retrigger: +50 ignored, +300 accepted
      clear_stats();
      pulse();
      step(47);
      pulse();
      step(247);
      pulse();
      step(REC + HOLDOFF + 20);
      chk_record("retrig", 512);
      chk("retrig_evt_const", 64'(evt_cnt), 64'd4);
      chk("retrig_nfirst", 64'(n_first), 64'd2);
      chk("retrig_nlast",  64'(n_last),  64'd2);

      // Backpressure: 10 dropped samples mid-record
      clear_stats();
      pulse();
      step($urandom_range(50, 150));
      wr_full = 1'b1;
      step(10);
      wr_full = 1'b0;
      step(REC + HOLDOFF + 20);
      chk_record("bp", 246);
      chk("bp_ovf_const", 64'(overflow), 64'd1);
      chk("bp_nlast", 64'(n_last), 64'd1);

      // Reset at record sample 100
      clear_stats();
      pulse();
      guard = 0;
      while (!(rec_on && m - rec_t - 2 == 100) && guard < 600) begin
         step(1);
         guard++;
      end
      chk("rst_mid_reached", 64'(guard < 600), 64'd1);
      chk("rst_mid_pre_valid", 64'(out_valid), 64'd1);
      RESET = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      chk("rst_mid_last",  64'(out_last),  64'd0);
      chk("rst_mid_busy",  64'(busy),      64'd0);
      chk("rst_mid_ovf",   64'(overflow),  64'd0);
      chk("rst_mid_evt",   64'(evt_cnt),   64'd0);
      step(3);
      RESET = 1'b1;
      clear_stats();
      step(40);
      pulse();
      step(100);
      chk("refill_evt",    64'(evt_cnt), 64'd0);
      chk("refill_nvalid", 64'(n_valid), 64'd0);
      clear_stats();
      pulse();
      step(REC + HOLDOFF + 20);
      chk_record("rearm", 256);
      chk("rearm_evt_const", 64'(evt_cnt), 64'd1);

`ifdef WFC_TIMESTAMP_EN
      // Trigger taken while the free-running counter reads 1234
      clear_stats();
      guard = 0;
      while (m < rst_edge + 1232 && guard < 3000) begin
         step(1);
         guard++;
      end
      pulse();
      step(REC + HOLDOFF + 20);
      chk_record("ts", 256);
      chk("ts_const", 64'(ts_out), 64'd1234);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
